// File: rtl/imem_port_arbiter.sv
// Instruction memory port arbiter: shares a single-port, fixed-latency
// instruction memory between the fetch stage and an auxiliary reader.
// One transaction in flight, fetch has priority, and a starvation counter
// forces the aux requester through after a bounded run of fetch grants.
module imem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    input  logic        f_flush,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [15:0] f_rdata,
    input  logic        a_req,
    input  logic [15:0] a_addr,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    output logic        m_en,
    output logic [15:0] m_addr,
    input  logic [15:0] m_rdata,
    output logic        busy
);

    typedef enum logic { ST_IDLE, ST_WAIT } state_t;
    typedef enum logic { OWN_F, OWN_A } owner_t;

    localparam logic [2:0] CNT_INIT   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    state_t      stateNext;
    owner_t      owner;
    logic [2:0]  cnt;
    logic        kill;
    logic [3:0]  starveCnt;
    logic        fRvalidReg;
    logic        aRvalidReg;
    logic [15:0] fRdataReg;
    logic [15:0] aRdataReg;
    logic [15:0] mAddrReg;
    logic        grantF;
    logic        grantA;
    logic        fetchOk;
    logic        starved;
    logic        done;
    logic        dropFetch;

    assign fetchOk   = f_req & ~f_flush;
    assign starved   = (starveCnt == STARVE_LIM);
    assign done      = (state == ST_WAIT) && (cnt == 3'd0);
    assign dropFetch = kill | f_flush;

    // Arbitration and next-state: grants only in IDLE, gated off while reset is held
    always_comb begin
        grantF    = 1'b0;
        grantA    = 1'b0;
        stateNext = state;
        if (state == ST_IDLE && !rst) begin
            if (a_req && (starved || !fetchOk)) begin
                grantA = 1'b1;
            end else if (fetchOk) begin
                grantF = 1'b1;
            end
            if (grantA || grantF) begin
                stateNext = ST_WAIT;
            end
        end else if (done) begin
            stateNext = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Transaction tracking: owner, latency countdown and fetch kill flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_F;
            cnt   <= 3'd0;
            kill  <= 1'b0;
        end else if (grantF || grantA) begin
            owner <= grantA ? OWN_A : OWN_F;
            cnt   <= CNT_INIT;
            kill  <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (done) begin
                kill <= 1'b0;
            end else if (owner == OWN_F && f_flush) begin
                kill <= 1'b1;
            end
        end
    end

    // Response capture: route memory data to the owner, dropping killed fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fRvalidReg <= 1'b0;
            aRvalidReg <= 1'b0;
            fRdataReg  <= 16'd0;
            aRdataReg  <= 16'd0;
        end else begin
            fRvalidReg <= done && (owner == OWN_F) && !dropFetch;
            aRvalidReg <= done && (owner == OWN_A);
            if (done && owner == OWN_F && !dropFetch) begin
                fRdataReg <= m_rdata;
            end
            if (done && owner == OWN_A) begin
                aRdataReg <= m_rdata;
            end
        end
    end

    // Starvation counter: counts fetch grants that bypass a waiting aux request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= 4'd0;
        end else if (!a_req || grantA) begin
            starveCnt <= 4'd0;
        end else if (grantF && !starved) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end

    // Memory address hold register so m_addr stays put between grants
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mAddrReg <= 16'd0;
        end else if (grantF || grantA) begin
            mAddrReg <= grantA ? a_addr : f_addr;
        end
    end

    assign f_gnt    = grantF;
    assign a_gnt    = grantA;
    assign m_en     = grantF | grantA;
    assign m_addr   = grantA ? a_addr : (grantF ? f_addr : mAddrReg);
    assign f_rvalid = fRvalidReg & ~f_flush;
    assign f_rdata  = fRdataReg;
    assign a_rvalid = aRvalidReg;
    assign a_rdata  = aRdataReg;
    assign busy     = (state == ST_WAIT);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter: one instance at MEM_LAT=2 and
// one at MEM_LAT=1, each backed by a small fixed-latency memory model whose
// word at address a is a ^ 16'hA5B5.
module tb_imem_port_arbiter;

    logic        clk;
    logic        rst;

    logic        fReq, fFlush, aReq;
    logic [15:0] fAddr, aAddr;
    logic        fGnt, fRvalid, aGnt, aRvalid, mEn, busy;
    logic [15:0] fRdata, aRdata, mAddr, mRdata;

    logic        fReqB;
    logic [15:0] fAddrB;
    logic        fGntB, fRvalidB, aGntB, aRvalidB, mEnB, busyB;
    logic [15:0] fRdataB, aRdataB, mAddrB, mRdataB;
    logic        zeroBit;
    logic [15:0] zeroWord;

    logic [15:0] memPipeA1, memPipeA2, memPipeB;

    int checks   = 0;
    int failures = 0;

    imem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(fReq), .f_addr(fAddr), .f_flush(fFlush),
        .f_gnt(fGnt), .f_rvalid(fRvalid), .f_rdata(fRdata),
        .a_req(aReq), .a_addr(aAddr),
        .a_gnt(aGnt), .a_rvalid(aRvalid), .a_rdata(aRdata),
        .m_en(mEn), .m_addr(mAddr), .m_rdata(mRdata),
        .busy(busy)
    );

    imem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dutB (
        .clk(clk), .rst(rst),
        .f_req(fReqB), .f_addr(fAddrB), .f_flush(zeroBit),
        .f_gnt(fGntB), .f_rvalid(fRvalidB), .f_rdata(fRdataB),
        .a_req(zeroBit), .a_addr(zeroWord),
        .a_gnt(aGntB), .a_rvalid(aRvalidB), .a_rdata(aRdataB),
        .m_en(mEnB), .m_addr(mAddrB), .m_rdata(mRdataB),
        .busy(busyB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] memWord(input logic [15:0] addr);
        return addr ^ 16'hA5B5;
    endfunction

    // Fixed-latency memory models; idle slots return a marker word
    always @(posedge clk) begin
        memPipeA1 <= mEn ? memWord(mAddr) : 16'hDEAD;
        memPipeA2 <= memPipeA1;
        memPipeB  <= mEnB ? memWord(mAddrB) : 16'hDEAD;
    end

    assign mRdata  = memPipeA2;
    assign mRdataB = memPipeB;
    assign zeroBit  = 1'b0;
    assign zeroWord = 16'd0;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fr, input logic [15:0] fa, input logic ff,
                                 input logic ar, input logic [15:0] aa);
        fReq   = fr;
        fAddr  = fa;
        fFlush = ff;
        aReq   = ar;
        aAddr  = aa;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expA;
        rst    = 1'b1;
        fReqB  = 1'b0;
        fAddrB = 16'd0;
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);

        // Reset state, with a fetch request already pending
        repeat (2) nextCycle();
        checkOutput("rstFGnt",    16'(fGnt),    16'd0);
        checkOutput("rstMEn",     16'(mEn),     16'd0);
        checkOutput("rstMAddr",   mAddr,        16'd0);
        checkOutput("rstBusy",    16'(busy),    16'd0);
        checkOutput("rstFRvalid", 16'(fRvalid), 16'd0);
        checkOutput("rstFRdata",  fRdata,       16'd0);

        // Basic fetch: grant at T, data at T+3
        rst = 1'b0;
        #1;
        checkOutput("s1FGnt",  16'(fGnt), 16'd1);
        checkOutput("s1MEn",   16'(mEn),  16'd1);
        checkOutput("s1MAddr", mAddr,     16'h0010);
        checkOutput("s1AGnt",  16'(aGnt), 16'd0);
        nextCycle();
        applyStimulus(1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("s1Busy",     16'(busy), 16'd1);
        checkOutput("s1WaitMEn",  16'(mEn),  16'd0);
        checkOutput("s1HoldAddr", mAddr,     16'h0010);
        nextCycle();
        #1;
        checkOutput("s1EarlyRv", 16'(fRvalid), 16'd0);
        nextCycle();
        #1;
        checkOutput("s1FRvalid", 16'(fRvalid), 16'd1);
        checkOutput("s1FRdata",  fRdata,       16'hA5A5);
        checkOutput("s1IdleBusy", 16'(busy),   16'd0);
        checkOutput("s1ARvalid", 16'(aRvalid), 16'd0);

        // Fetch killed by a flush in WAIT
        nextCycle();
        applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("flGnt", 16'(fGnt), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0020, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("flBusy", 16'(busy), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("flEarlyRv", 16'(fRvalid), 16'd0);
        nextCycle();
        #1;
        checkOutput("flNoRvalid", 16'(fRvalid), 16'd0);
        checkOutput("flRdataKept", fRdata,      16'hA5A5);
        checkOutput("flBusyLow",  16'(busy),    16'd0);
        applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("flRegrant", 16'(fGnt), 16'd1);
        checkOutput("flRegAddr", mAddr,     16'h0030);
        nextCycle();
        applyStimulus(1'b0, 16'h0030, 1'b0, 1'b0, 16'h0000);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("flNextRv",    16'(fRvalid), 16'd1);
        checkOutput("flNextRdata", fRdata,       16'hA585);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("flRvMasked", 16'(fRvalid), 16'd0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

        // Aux read unaffected by a flush pulse
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
        #1;
        checkOutput("axAGnt",  16'(aGnt), 16'd1);
        checkOutput("axFGnt",  16'(fGnt), 16'd0);
        checkOutput("axMAddr", mAddr,     16'h0100);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100);
        #1;
        checkOutput("axBusy", 16'(busy), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        nextCycle();
        #1;
        checkOutput("axARvalid", 16'(aRvalid), 16'd1);
        checkOutput("axARdata",  aRdata,       16'hA4B5);
        checkOutput("axFRdata",  fRdata,       16'hA585);
        checkOutput("axFRvalid", 16'(fRvalid), 16'd0);

        // Starvation: both requesters held, pattern F,F,F,F,A repeating
        nextCycle();
        applyStimulus(1'b1, 16'h0200, 1'b0, 1'b1, 16'h0300);
        for (int k = 0; k < 10; k++) begin
            #1;
            expA = ((k % 5) == 4);
            checkOutput($sformatf("stF%0d", k), 16'(fGnt), 16'(!expA));
            checkOutput($sformatf("stA%0d", k), 16'(aGnt), 16'(expA));
            if (k > 0) begin
                if ((k % 5) == 0) begin
                    checkOutput($sformatf("stARv%0d", k), 16'(aRvalid), 16'd1);
                    checkOutput($sformatf("stARd%0d", k), aRdata,       16'hA6B5);
                end else begin
                    checkOutput($sformatf("stFRv%0d", k), 16'(fRvalid), 16'd1);
                    checkOutput($sformatf("stFRd%0d", k), fRdata,       16'hA7B5);
                end
            end
            nextCycle();
            #1;
            checkOutput($sformatf("stWaitGnt%0d", k), 16'({fGnt, aGnt}), 16'd0);
            nextCycle();
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("stLastARv", 16'(aRvalid), 16'd1);

        // Reset in the middle of WAIT drops the transaction
        nextCycle();
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("mrGnt", 16'(fGnt), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        #1;
        checkOutput("mrBusy",    16'(busy),    16'd0);
        checkOutput("mrMEn",     16'(mEn),     16'd0);
        checkOutput("mrMAddr",   mAddr,        16'd0);
        checkOutput("mrFRdata",  fRdata,       16'd0);
        checkOutput("mrARdata",  aRdata,       16'd0);
        checkOutput("mrFRvalid", 16'(fRvalid), 16'd0);
        checkOutput("mrARvalid", 16'(aRvalid), 16'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        #1;
        checkOutput("mrNoRv1", 16'(fRvalid), 16'd0);
        nextCycle();
        #1;
        checkOutput("mrNoRv2",  16'(fRvalid), 16'd0);
        checkOutput("mrIdle",   16'(busy),    16'd0);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);
        #1;
        checkOutput("mrFGnt",  16'(fGnt), 16'd1);
        checkOutput("mrGMAddr", mAddr,    16'h0010);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("mrFRv",    16'(fRvalid), 16'd1);
        checkOutput("mrFRdat",  fRdata,       16'hA5A5);

        // MEM_LAT=1 streaming: one fetch every two cycles
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            fReqB  = (i < 4);
            fAddrB = 16'(i);
            #1;
            if (i > 0) begin
                checkOutput($sformatf("l1Rv%0d", i), 16'(fRvalidB), 16'd1);
                checkOutput($sformatf("l1Rd%0d", i), fRdataB, memWord(16'(i - 1)));
            end
            if (i < 4) begin
                checkOutput($sformatf("l1MEn%0d", i),   16'(mEnB), 16'd1);
                checkOutput($sformatf("l1MAddr%0d", i), mAddrB,    16'(i));
            end
            nextCycle();
            #1;
            checkOutput($sformatf("l1WaitRv%0d", i),  16'(fRvalidB), 16'd0);
            checkOutput($sformatf("l1WaitMEn%0d", i), 16'(mEnB),     16'd0);
            nextCycle();
        end
        checkOutput("l1AGnt", 16'(aGntB), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port, fixed-latency 16-bit instruction memory between two requesters: the fetch stage (F) and an auxiliary reader (A), such as the crypto core's key/table loader.
- Holds at most one transaction in flight. Fetch has priority, and a starvation counter guarantees aux forward progress.
- Supports fetch flush on branch redirect: an in-flight fetch response is discarded.
- Sits between the fetch-stage PC/instruction-memory path and the memory macro.

Parameters:
- MEM_LAT, 2, cycles from the m_en cycle to m_rdata valid (legal range 1..7).
- STARVE_MAX, 4, consecutive fetch grants allowed while a_req is pending before aux is forced through (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- f_req  input  1  fetch request; held high until f_gnt.
- f_addr  input  16  fetch word address.
- f_flush  input  1  redirect; kills the pending/in-flight fetch.
- f_gnt  output  1  fetch request accepted (combinational, IDLE only).
- f_rvalid  output  1  fetch data valid, 1-cycle pulse.
- f_rdata  output  16  fetch instruction word.
- a_req  input  1  aux request; held high until a_gnt.
- a_addr  input  16  aux word address.
- a_gnt  output  1  aux request accepted.
- a_rvalid  output  1  aux data valid, 1-cycle pulse.
- a_rdata  output  16  aux data word.
- m_en  output  1  memory read strobe, 1 cycle per transaction.
- m_addr  output  16  memory address.
- m_rdata  input  16  memory read data, valid MEM_LAT cycles after m_en.
- busy  output  1  high while in WAIT.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; owner, kill and starve_cnt cleared.
  - All outputs 0, including f_rdata, a_rdata and m_addr.
  - Any in-flight transaction is dropped and produces no rvalid after reset deasserts.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: transaction outstanding; 3-bit countdown cnt is active.
- Arbitration (IDLE only, combinational):
  - fetch_ok = f_req & ~f_flush.
  - If a_req & (starve_cnt==STARVE_MAX | ~fetch_ok): grant A.
  - Else if fetch_ok: grant F.
  - Else: no grant.
- Grant cycle:
  - Exactly one of f_gnt/a_gnt is high.
  - m_en=1; m_addr = selected address (combinational).
  - owner is latched; cnt is loaded with MEM_LAT-1; next state is WAIT.
  - Outside a grant cycle, m_en=0 and m_addr holds its last value.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==0: m_rdata is registered into the owner's rdata register, the owner's rvalid register is set for the next cycle, and the next state is IDLE.
- Timing:
  - Grant at cycle T gives rvalid at T+MEM_LAT+1.
  - Peak throughput is one transaction per MEM_LAT+1 cycles.
  - The rvalid cycle is an IDLE cycle, so a new grant may occur in that same cycle.
- rdata:
  - Each rdata output holds its value until that requester's next capture.
  - The non-owner's rdata is unchanged.
- Starvation counter starve_cnt (4-bit):
  - Incremented on an F grant while a_req=1.
  - Cleared on an A grant, or whenever a_req=0.
  - Saturates at STARVE_MAX.
- Flush:
  - f_flush in IDLE blocks the fetch grant that cycle.
  - f_flush in WAIT with owner=F sets kill. The transaction still completes in memory, but f_rvalid is suppressed and f_rdata is not updated. kill clears on return to IDLE.
  - f_flush in the f_rvalid cycle: f_rvalid = rvalid_reg & ~f_flush.
  - f_flush has no effect on aux transactions.
- Simultaneous events:
  - f_req and a_req together with starve_cnt<STARVE_MAX: F wins.
  - Requests raised during WAIT are not granted until IDLE.
  - Requesters must hold req and addr stable until gnt.
- busy = (state==WAIT).

Test Plan:
- MEM_LAT=2, reset released, f_req=1, f_addr=0x0010, memory returns 0xA5A5 -> f_gnt and m_en at T with m_addr=0x0010; f_rvalid=1 at T+3 with f_rdata=0xA5A5; a_gnt never asserted.
- f_req and a_req held high continuously, STARVE_MAX=4 -> grant sequence F,F,F,F,A,F,F,F,F,A,...; every a_gnt preceded by exactly 4 f_gnt.
- Fetch granted at T, f_flush=1 at T+1 -> no f_rvalid at T+3; f_rdata keeps its previous value; busy falls at T+3; next grant possible at T+3.
- Aux granted at T, f_flush pulsed at T+1 -> a_rvalid at T+3 with correct data; no effect on aux.
- rst asserted at T+1 mid-WAIT -> all outputs 0 immediately; after release, no spurious rvalid; first new grant behaves as in scenario 1.
- MEM_LAT=1, f_req held high, addresses 0..3 -> f_rvalid every 2 cycles with data of addresses 0,1,2,3 in order; m_en pulses coincide with f_rvalid cycles after the first.
